// File: rtl/matmul_dot_accumulator.sv
// ---------------------------------------------------------------------------
// matmul_dot_accumulator
//
// Purpose:
//   Sums runs of signed products coming from the MatrixMultiplication
//   multiplier into dot-product elements. A job is started with a row
//   length (cfg_len) and a row count (cfg_rows). The block then emits one
//   element per run of cfg_len products, cfg_rows times. All arithmetic
//   wraps modulo 2^ACC_WIDTH, which matches the multiplier's truncated
//   products.
//
// Ports:
//   ap_clk     in   1           clock, rising edge
//   ap_rst_n   in   1           asynchronous active-low reset
//   start      in   1           begin a job (sampled only when idle)
//   cfg_len    in   LEN_WIDTH   products per dot product
//   cfg_rows   in   ROWS_WIDTH  dot products per job
//   busy       out  1           job in progress (any state but IDLE)
//   done       out  1           one-cycle pulse after the last output
//   in_data    in   DATA_WIDTH  signed product
//   in_valid   in   1           in_data valid
//   in_ready   out  1           product accepted this cycle
//   out_data   out  ACC_WIDTH   signed dot-product result
//   out_valid  out  1           out_data valid
//   out_ready  in   1           consumer accepts out_data
// ---------------------------------------------------------------------------
module matmul_dot_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ROWS_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [ROWS_WIDTH-1:0] cfg_rows,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_term;
    logic [ROWS_WIDTH-1:0] r_rows;
    logic [ROWS_WIDTH-1:0] r_row;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH-1:0]  r_out;

    logic                  w_beat;
    logic                  w_out_hs;
    logic                  w_last_term;
    logic                  w_last_row;
    logic [ACC_WIDTH-1:0]  w_ext;
    logic [ACC_WIDTH-1:0]  w_sum;

    // Products are signed; widen with sign extension before adding so a
    // wider accumulator still sums negative terms correctly.
    assign w_ext       = ACC_WIDTH'($signed(in_data));
    assign w_sum       = r_acc + w_ext;
    assign w_beat      = (r_state == S_ACCUM) && in_valid;
    assign w_out_hs    = (r_state == S_OUTPUT) && out_ready;
    // len/rows are never zero when these compares are consulted: a zero
    // length never enters ACCUM and a zero row count never enters OUTPUT.
    assign w_last_term = (r_term == (r_len - LEN_WIDTH'(1)));
    assign w_last_row  = (r_row == (r_rows - ROWS_WIDTH'(1)));

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_rows == ROWS_WIDTH'(0)) begin
                        w_next_state = S_DONE;
                    end else if (cfg_len == LEN_WIDTH'(0)) begin
                        w_next_state = S_OUTPUT;
                    end else begin
                        w_next_state = S_ACCUM;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (w_beat && w_last_term) begin
                    w_next_state = S_OUTPUT;
                end else begin
                    w_next_state = S_ACCUM;
                end
            end
            S_OUTPUT: begin
                if (w_out_hs) begin
                    if (w_last_row) begin
                        w_next_state = S_DONE;
                    end else if (r_len == LEN_WIDTH'(0)) begin
                        // Zero-length rows go straight to the next output.
                        w_next_state = S_OUTPUT;
                    end else begin
                        w_next_state = S_ACCUM;
                    end
                end else begin
                    w_next_state = S_OUTPUT;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: configuration latch, accumulator, counters and result.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_len  <= LEN_WIDTH'(0);
            r_rows <= ROWS_WIDTH'(0);
            r_term <= LEN_WIDTH'(0);
            r_row  <= ROWS_WIDTH'(0);
            r_acc  <= ACC_WIDTH'(0);
            r_out  <= ACC_WIDTH'(0);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len  <= cfg_len;
                        r_rows <= cfg_rows;
                        r_term <= LEN_WIDTH'(0);
                        r_row  <= ROWS_WIDTH'(0);
                        r_acc  <= ACC_WIDTH'(0);
                        // Zero-length jobs present this cleared value.
                        r_out  <= ACC_WIDTH'(0);
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        if (w_last_term) begin
                            // Final term goes straight into the result so
                            // out_valid follows the last beat by one cycle.
                            r_out  <= w_sum;
                            r_acc  <= ACC_WIDTH'(0);
                            r_term <= LEN_WIDTH'(0);
                        end else begin
                            r_acc  <= w_sum;
                            r_term <= r_term + LEN_WIDTH'(1);
                        end
                    end
                end
                S_OUTPUT: begin
                    if (w_out_hs) begin
                        r_row <= r_row + ROWS_WIDTH'(1);
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign out_data = r_out;

endmodule
